// File: rtl/bp_be_issue_sequencer.sv
// Purpose: selects the next op for the BE decoder (debug enter/exit, interrupt, or FE queue head)
//   into a one-entry issue slot.
// Latency: FE handshake in cycle N -> issue_v_o in N+1; request pulse -> injected op in slot at N+2.
// Backpressure: slot holds stable while issue_ready_i=0; a dispatched serial op stalls all loading
//   until serial_done_i.
// Ports: fe_* FE queue entry (valid/ready); enter/exit_debug_req_i, interrupt_* injection sources;
//   dec_* slot fields to decoder, serial_i decoder's serial flag for them; issue_v_o/issue_ready_i
//   dispatch handshake; serial_done_i commit retire; flush_i drops slot; debug_mode_o,
//   serial_timeout_o status.
module bp_be_issue_sequencer
  #(parameter int instr_width_p    = 32
    ,parameter int fe_exc_width_p   = 2
    ,parameter int serial_timeout_p = 255
    )
  (input  logic                      clk_i
   ,input  logic                      reset_i

   ,input  logic                      fe_v_i
   ,output logic                      fe_ready_o
   ,input  logic [instr_width_p-1:0]  fe_instr_i
   ,input  logic                      fe_exc_not_instr_i
   ,input  logic [fe_exc_width_p-1:0] fe_exc_i

   ,input  logic                      enter_debug_req_i
   ,input  logic                      exit_debug_req_i
   ,input  logic                      interrupt_pending_i
   ,input  logic                      interrupt_en_i

   ,output logic                      dec_enter_debug_v_o
   ,output logic                      dec_exit_debug_v_o
   ,output logic                      dec_interrupt_v_o
   ,output logic                      dec_fe_exc_not_instr_o
   ,output logic [fe_exc_width_p-1:0] dec_fe_exc_o
   ,output logic [instr_width_p-1:0]  dec_instr_o
   ,input  logic                      serial_i

   ,output logic                      issue_v_o
   ,input  logic                      issue_ready_i
   ,input  logic                      serial_done_i
   ,input  logic                      flush_i

   ,output logic                      debug_mode_o
   ,output logic                      serial_timeout_o
   );

  localparam int cnt_width_lp = $clog2(serial_timeout_p+1);
  localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(serial_timeout_p);

  typedef enum logic [1:0] {e_empty, e_full, e_serial_wait} state_e;

  state_e state_r, state_n;
  logic   enter_pend_r, exit_pend_r, debug_mode_r;
  logic [cnt_width_lp-1:0] cnt_r;

  logic                      slot_enter_r, slot_exit_r, slot_int_r, slot_exc_not_instr_r;
  logic [fe_exc_width_p-1:0] slot_exc_r;
  logic [instr_width_p-1:0]  slot_instr_r;

  logic is_full, accept, load, irq_v, inj_any;
  logic inj_enter, inj_exit, inj_irq, fe_take, load_v;

  // Flush blocks acceptance, so a flushed slot never counts as dispatched and never reloads.
  assign is_full   = (state_r == e_full);
  assign accept    = is_full & issue_ready_i & ~flush_i;
  assign load      = (state_r == e_empty) | (accept & ~serial_i);
  assign irq_v     = interrupt_pending_i & interrupt_en_i & ~debug_mode_r;
  assign inj_any   = enter_pend_r | exit_pend_r | irq_v;
  assign inj_enter = load & enter_pend_r;
  assign inj_exit  = load & ~enter_pend_r & exit_pend_r;
  assign inj_irq   = load & ~enter_pend_r & ~exit_pend_r & irq_v;
  assign fe_ready_o = load & ~inj_any & ~reset_i;
  assign fe_take   = fe_ready_o & fe_v_i;
  assign load_v    = inj_enter | inj_exit | inj_irq | fe_take;

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_empty:       if (load_v) state_n = e_full;
      e_full: begin
        if (flush_i)     state_n = e_empty;
        else if (accept) state_n = serial_i ? e_serial_wait : (load_v ? e_full : e_empty);
      end
      e_serial_wait: if (serial_done_i) state_n = e_empty;
      default:       state_n = e_empty;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_empty;
    else         state_r <= state_n;
  end

  // Slot: a load overwrites every field; leaving FULL without a load clears it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot_enter_r         <= 1'b0;
      slot_exit_r          <= 1'b0;
      slot_int_r           <= 1'b0;
      slot_exc_not_instr_r <= 1'b0;
      slot_exc_r           <= '0;
      slot_instr_r         <= '0;
    end else if (load_v) begin
      slot_enter_r         <= inj_enter;
      slot_exit_r          <= inj_exit;
      slot_int_r           <= inj_irq;
      slot_exc_not_instr_r <= fe_take & fe_exc_not_instr_i;
      slot_exc_r           <= fe_take ? fe_exc_i : '0;
      slot_instr_r         <= fe_take ? fe_instr_i : '0;
    end else if (is_full & (flush_i | accept)) begin
      slot_enter_r         <= 1'b0;
      slot_exit_r          <= 1'b0;
      slot_int_r           <= 1'b0;
      slot_exc_not_instr_r <= 1'b0;
      slot_exc_r           <= '0;
      slot_instr_r         <= '0;
    end
  end

  // Requests illegal for the current mode are dropped rather than queued.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      enter_pend_r <= 1'b0;
      exit_pend_r  <= 1'b0;
      debug_mode_r <= 1'b0;
    end else begin
      if (enter_debug_req_i & ~debug_mode_r) enter_pend_r <= 1'b1;
      else if (inj_enter)                    enter_pend_r <= 1'b0;
      if (exit_debug_req_i & debug_mode_r)   exit_pend_r  <= 1'b1;
      else if (inj_exit)                     exit_pend_r  <= 1'b0;
      if (accept & slot_enter_r)             debug_mode_r <= 1'b1;
      else if (accept & slot_exit_r)         debug_mode_r <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      cnt_r <= '0;
    else if ((state_r != e_serial_wait) && (state_n == e_serial_wait))
      cnt_r <= '0;
    else if ((state_r == e_serial_wait) && (cnt_r != cnt_max_lp))
      cnt_r <= cnt_r + 1'b1;
  end

  assign issue_v_o              = is_full;
  assign debug_mode_o           = debug_mode_r;
  assign serial_timeout_o       = (state_r == e_serial_wait) & (cnt_r == cnt_max_lp);
  assign dec_enter_debug_v_o    = slot_enter_r;
  assign dec_exit_debug_v_o     = slot_exit_r;
  assign dec_interrupt_v_o      = slot_int_r;
  assign dec_fe_exc_not_instr_o = slot_exc_not_instr_r;
  assign dec_fe_exc_o           = slot_exc_r;
  assign dec_instr_o            = slot_instr_r;

endmodule

// File: tb/tb_bp_be_issue_sequencer.sv
// Purpose: directed self-checking bench for bp_be_issue_sequencer (serial_timeout_p=3).
// Inputs change at the falling edge; outputs are sampled 1ns later, mid-cycle.
// Each scenario task leaves the DUT empty with all inputs idle.
module tb_bp_be_issue_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        fe_v_i, fe_ready_o, fe_exc_not_instr_i;
  logic [31:0] fe_instr_i;
  logic [1:0]  fe_exc_i;
  logic        enter_debug_req_i, exit_debug_req_i, interrupt_pending_i, interrupt_en_i;
  logic        dec_enter_debug_v_o, dec_exit_debug_v_o, dec_interrupt_v_o, dec_fe_exc_not_instr_o;
  logic [1:0]  dec_fe_exc_o;
  logic [31:0] dec_instr_o;
  logic        serial_i, issue_v_o, issue_ready_i, serial_done_i, flush_i;
  logic        debug_mode_o, serial_timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bp_be_issue_sequencer #(.instr_width_p(32), .fe_exc_width_p(2), .serial_timeout_p(3)) dut
    (.clk_i(clk_i), .reset_i(reset_i)
     ,.fe_v_i(fe_v_i), .fe_ready_o(fe_ready_o), .fe_instr_i(fe_instr_i)
     ,.fe_exc_not_instr_i(fe_exc_not_instr_i), .fe_exc_i(fe_exc_i)
     ,.enter_debug_req_i(enter_debug_req_i), .exit_debug_req_i(exit_debug_req_i)
     ,.interrupt_pending_i(interrupt_pending_i), .interrupt_en_i(interrupt_en_i)
     ,.dec_enter_debug_v_o(dec_enter_debug_v_o), .dec_exit_debug_v_o(dec_exit_debug_v_o)
     ,.dec_interrupt_v_o(dec_interrupt_v_o), .dec_fe_exc_not_instr_o(dec_fe_exc_not_instr_o)
     ,.dec_fe_exc_o(dec_fe_exc_o), .dec_instr_o(dec_instr_o), .serial_i(serial_i)
     ,.issue_v_o(issue_v_o), .issue_ready_i(issue_ready_i), .serial_done_i(serial_done_i)
     ,.flush_i(flush_i), .debug_mode_o(debug_mode_o), .serial_timeout_o(serial_timeout_o)
     );

  task automatic idle();
    fe_v_i = 0; fe_instr_i = '0; fe_exc_not_instr_i = 0; fe_exc_i = '0;
    enter_debug_req_i = 0; exit_debug_req_i = 0; interrupt_pending_i = 0; interrupt_en_i = 0;
    serial_i = 0; issue_ready_i = 0; serial_done_i = 0; flush_i = 0;
  endtask

  task automatic test_reset();
    idle();
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (issue_v_o !== 1'b0) begin errors++; $display("FAIL rst_issue_v: got %b want 0", issue_v_o); end
    checks++; if (fe_ready_o !== 1'b0) begin errors++; $display("FAIL rst_fe_ready: got %b want 0", fe_ready_o); end
    checks++; if (debug_mode_o !== 1'b0) begin errors++; $display("FAIL rst_debug_mode: got %b want 0", debug_mode_o); end
    checks++; if (serial_timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", serial_timeout_o); end
    checks++; if (dec_instr_o !== 32'h0) begin errors++; $display("FAIL rst_dec_instr: got %h want 0", dec_instr_o); end
    @(negedge clk_i); reset_i = 1'b0; #1;
    checks++; if (fe_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_fe_ready: got %b want 1", fe_ready_o); end
  endtask

  task automatic test_streaming();
    logic [31:0] instrs [4];
    instrs[0] = 32'h00000013; instrs[1] = 32'h00100093;
    instrs[2] = 32'h00200113; instrs[3] = 32'h00300193;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      issue_ready_i = 1; serial_i = 0;
      if (i < 4) begin fe_v_i = 1; fe_instr_i = instrs[i]; end
      else begin fe_v_i = 0; fe_instr_i = '0; end
      #1;
      checks++; if (fe_ready_o !== 1'b1) begin errors++; $display("FAIL stream_fe_ready[%0d]: got %b want 1", i, fe_ready_o); end
      checks++; if (issue_v_o !== (i > 0)) begin errors++; $display("FAIL stream_issue_v[%0d]: got %b want %b", i, issue_v_o, (i > 0)); end
      if (i > 0) begin
        checks++; if (dec_instr_o !== instrs[i-1]) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, dec_instr_o, instrs[i-1]); end
      end
    end
    @(negedge clk_i); idle(); #1;
    checks++; if (issue_v_o !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", issue_v_o); end
  endtask

  task automatic test_serial();
    @(negedge clk_i); fe_v_i = 1; fe_instr_i = 32'h0000100f; issue_ready_i = 1; #1;
    @(negedge clk_i); fe_instr_i = 32'h00000013; serial_i = 1; serial_done_i = 1; #1;
    checks++; if (dec_instr_o !== 32'h0000100f) begin errors++; $display("FAIL serial_slot: got %h want 0000100f", dec_instr_o); end
    checks++; if (fe_ready_o !== 1'b0) begin errors++; $display("FAIL serial_accept_fe_ready: got %b want 0", fe_ready_o); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i); serial_i = 0; serial_done_i = (j == 2); #1;
      checks++; if (fe_ready_o !== 1'b0) begin errors++; $display("FAIL serial_wait_fe_ready[%0d]: got %b want 0", j, fe_ready_o); end
      checks++; if (issue_v_o !== 1'b0) begin errors++; $display("FAIL serial_wait_issue_v[%0d]: got %b want 0", j, issue_v_o); end
    end
    @(negedge clk_i); serial_done_i = 0; #1;
    checks++; if (issue_v_o !== 1'b0) begin errors++; $display("FAIL serial_done_empty: got %b want 0", issue_v_o); end
    checks++; if (fe_ready_o !== 1'b1) begin errors++; $display("FAIL serial_done_fe_ready: got %b want 1", fe_ready_o); end
    @(negedge clk_i); fe_v_i = 0; #1;
    checks++; if (issue_v_o !== 1'b1 || dec_instr_o !== 32'h00000013) begin errors++; $display("FAIL serial_next_issue: got v=%b %h want v=1 00000013", issue_v_o, dec_instr_o); end
    @(negedge clk_i); idle(); #1;
  endtask

  task automatic test_timeout();
    @(negedge clk_i); fe_v_i = 1; fe_instr_i = 32'h0000100f; issue_ready_i = 1; #1;
    @(negedge clk_i); fe_v_i = 0; serial_i = 1; #1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk_i); serial_i = 0; flush_i = (j == 1); serial_done_i = (j == 5); #1;
      checks++; if (serial_timeout_o !== (j >= 3)) begin errors++; $display("FAIL timeout[%0d]: got %b want %b", j, serial_timeout_o, (j >= 3)); end
      if (j == 2) begin
        checks++; if (fe_ready_o !== 1'b0) begin errors++; $display("FAIL timeout_flush_ignored: got %b want 0", fe_ready_o); end
      end
    end
    @(negedge clk_i); serial_done_i = 0; flush_i = 0; #1;
    checks++; if (serial_timeout_o !== 1'b0 || fe_ready_o !== 1'b1) begin errors++; $display("FAIL timeout_release: got to=%b rdy=%b want to=0 rdy=1", serial_timeout_o, fe_ready_o); end
    idle();
  endtask

  task automatic test_backpressure_flush();
    @(negedge clk_i); fe_v_i = 1; fe_instr_i = 32'hdeadbeef; fe_exc_not_instr_i = 1; fe_exc_i = 2'd2; #1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i); fe_instr_i = 32'h00000013; fe_exc_not_instr_i = 0; fe_exc_i = '0; #1;
      checks++; if (issue_v_o !== 1'b1 || dec_instr_o !== 32'hdeadbeef || dec_fe_exc_o !== 2'd2 || dec_fe_exc_not_instr_o !== 1'b1)
        begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h exc=%0d nx=%b want v=1 deadbeef exc=2 nx=1", j, issue_v_o, dec_instr_o, dec_fe_exc_o, dec_fe_exc_not_instr_o); end
      checks++; if (fe_ready_o !== 1'b0) begin errors++; $display("FAIL bp_fe_ready[%0d]: got %b want 0", j, fe_ready_o); end
    end
    @(negedge clk_i); flush_i = 1; issue_ready_i = 1; #1;
    checks++; if (fe_ready_o !== 1'b0) begin errors++; $display("FAIL flush_fe_ready: got %b want 0", fe_ready_o); end
    @(negedge clk_i); flush_i = 0; fe_v_i = 0; #1;
    checks++; if (issue_v_o !== 1'b0 || dec_instr_o !== 32'h0) begin errors++; $display("FAIL flush_empty: got v=%b %h want v=0 0", issue_v_o, dec_instr_o); end
    idle();
  endtask

  task automatic test_priority();
    @(negedge clk_i); fe_v_i = 1; fe_instr_i = 32'h11111111; #1;
    @(negedge clk_i); enter_debug_req_i = 1; interrupt_pending_i = 1; interrupt_en_i = 1; fe_instr_i = 32'h22222222; #1;
    @(negedge clk_i); enter_debug_req_i = 0; issue_ready_i = 1; #1;
    checks++; if (fe_ready_o !== 1'b0) begin errors++; $display("FAIL prio_fe_blocked: got %b want 0", fe_ready_o); end
    @(negedge clk_i); issue_ready_i = 0; #1;
    checks++; if (dec_enter_debug_v_o !== 1'b1 || dec_interrupt_v_o !== 1'b0 || dec_instr_o !== 32'h0)
      begin errors++; $display("FAIL prio_enter_slot: got en=%b int=%b %h want en=1 int=0 0", dec_enter_debug_v_o, dec_interrupt_v_o, dec_instr_o); end
    checks++; if (debug_mode_o !== 1'b0) begin errors++; $display("FAIL prio_debug_before_accept: got %b want 0", debug_mode_o); end
    @(negedge clk_i); issue_ready_i = 1; interrupt_en_i = 0; fe_v_i = 0; #1;
    @(negedge clk_i); issue_ready_i = 0; interrupt_en_i = 1; fe_v_i = 1; #1;
    checks++; if (debug_mode_o !== 1'b1) begin errors++; $display("FAIL prio_debug_set: got %b want 1", debug_mode_o); end
    checks++; if (fe_ready_o !== 1'b1) begin errors++; $display("FAIL prio_irq_masked_in_debug: got %b want 1", fe_ready_o); end
    @(negedge clk_i); fe_v_i = 0; exit_debug_req_i = 1; enter_debug_req_i = 1; #1;
    checks++; if (dec_interrupt_v_o !== 1'b0 || dec_instr_o !== 32'h22222222) begin errors++; $display("FAIL prio_fe_in_debug: got int=%b %h want int=0 22222222", dec_interrupt_v_o, dec_instr_o); end
    @(negedge clk_i); exit_debug_req_i = 0; enter_debug_req_i = 0; issue_ready_i = 1; #1;
    checks++; if (fe_ready_o !== 1'b0) begin errors++; $display("FAIL prio_exit_pending: got %b want 0", fe_ready_o); end
    @(negedge clk_i); #1;
    checks++; if (dec_exit_debug_v_o !== 1'b1 || dec_enter_debug_v_o !== 1'b0) begin errors++; $display("FAIL prio_exit_slot: got ex=%b en=%b want ex=1 en=0", dec_exit_debug_v_o, dec_enter_debug_v_o); end
    @(negedge clk_i); #1;
    checks++; if (debug_mode_o !== 1'b0) begin errors++; $display("FAIL prio_debug_clear: got %b want 0", debug_mode_o); end
    checks++; if (fe_ready_o !== 1'b0) begin errors++; $display("FAIL prio_irq_unmasked: got %b want 0", fe_ready_o); end
    @(negedge clk_i); interrupt_pending_i = 0; #1;
    checks++; if (dec_interrupt_v_o !== 1'b1 || issue_v_o !== 1'b1) begin errors++; $display("FAIL prio_irq_slot: got int=%b v=%b want int=1 v=1", dec_interrupt_v_o, issue_v_o); end
    @(negedge clk_i); idle(); #1;
    checks++; if (issue_v_o !== 1'b0) begin errors++; $display("FAIL prio_drain: got %b want 0", issue_v_o); end
  endtask

  task automatic test_async_reset();
    @(negedge clk_i); enter_debug_req_i = 1; issue_ready_i = 1; #1;
    @(negedge clk_i); enter_debug_req_i = 0; #1;
    @(negedge clk_i); #1;
    @(negedge clk_i); fe_v_i = 1; fe_instr_i = 32'h0000100f; #1;
    @(negedge clk_i); fe_v_i = 0; serial_i = 1; #1;
    repeat (3) begin @(negedge clk_i); serial_i = 0; #1; end
    @(negedge clk_i); #1;
    checks++; if (serial_timeout_o !== 1'b1 || debug_mode_o !== 1'b1) begin errors++; $display("FAIL areset_pre: got to=%b dbg=%b want to=1 dbg=1", serial_timeout_o, debug_mode_o); end
    #1; reset_i = 1'b1; #1;
    checks++; if (serial_timeout_o !== 1'b0 || debug_mode_o !== 1'b0 || issue_v_o !== 1'b0 || fe_ready_o !== 1'b0)
      begin errors++; $display("FAIL areset_immediate: got to=%b dbg=%b v=%b rdy=%b want all 0", serial_timeout_o, debug_mode_o, issue_v_o, fe_ready_o); end
    @(negedge clk_i); reset_i = 1'b0; #1;
    checks++; if (fe_ready_o !== 1'b1 || serial_timeout_o !== 1'b0) begin errors++; $display("FAIL areset_empty: got rdy=%b to=%b want rdy=1 to=0", fe_ready_o, serial_timeout_o); end
    idle();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_serial();
    test_timeout();
    test_backpressure_flush();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
